// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between an instruction-fetch and a data (load/store) requester.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive losses.
module mem_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e     state_q;
  logic       store_q;
  logic [3:0] starve_q;
  logic [3:0] starve_d;
  logic       force_fetch;

  // Grants are gated by reset so every output is 0 while reset is held low.
  always_comb begin
    force_fetch = if_req && (starve_q == LIMIT);
    d_gnt       = reset && d_req && !force_fetch;
    if_gnt      = reset && if_req && !d_gnt;
    starve_d    = (if_req && !if_gnt) ? starve_q + 4'd1 : 4'd0;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end
  end

  // Owner of the previous cycle's grant; the response is returned while owning.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
      store_q  <= d_gnt && d_we;
      if (if_gnt)     state_q <= FETCH;
      else if (d_gnt) state_q <= DATA;
      else            state_q <= IDLE;
    end
  end

  always_comb begin
    if_valid = (state_q == FETCH);
    d_valid  = (state_q == DATA);
    if_rdata = if_valid ? mem_rdata : '0;
    d_rdata  = (d_valid && !store_q) ? mem_rdata : '0;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 16: data word width.
REQ-002 Parameter ADDR_W, default 16: word address width.
REQ-003 Parameter STARVE_LIMIT, default 3: consecutive fetch losses before fetch is forced to win; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 if_req  input  1  fetch-stage read request; held stable with if_addr until granted.
REQ-007 if_addr  input  ADDR_W  fetch address.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_valid  output  1  if_rdata valid this cycle.
REQ-010 if_rdata  output  DATA_W  fetched word.
REQ-011 d_req  input  1  MEM-stage request; held stable with d_we, d_addr and d_wdata until granted.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  ADDR_W  data address.
REQ-014 d_wdata  input  DATA_W  store data.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_valid  output  1  load data valid, or store completed, this cycle.
REQ-017 d_rdata  output  DATA_W  loaded word.
REQ-018 mem_en, mem_we  output  1 each  single-port synchronous memory enable and write strobe.
REQ-019 mem_addr, mem_wdata  output  ADDR_W, DATA_W  memory address and write data.
REQ-020 mem_rdata  input  DATA_W  memory read data, valid one cycle after a read enable.

Function
REQ-021 Per cycle, at most one request shall be granted; the grant decision and the mem_* drive shall be combinational from the current requests and the registered state.
REQ-022 Default priority shall be data over fetch; when both request, d_gnt=1 and if_gnt=0.
REQ-023 A 4-bit starve counter shall increment each cycle in which if_req=1 and if_gnt=0, clear when if_gnt=1, and clear when if_req=0.
REQ-024 When the starve counter equals STARVE_LIMIT and if_req=1, fetch shall win even if d_req=1.
REQ-025 Granted fetch: mem_en=1, mem_we=0, mem_addr=if_addr.
REQ-026 Granted data: mem_en=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata.
REQ-027 With no grant, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-028 The owner FSM shall use states IDLE, FETCH and DATA, holding the owner of the previous cycle's grant.
REQ-029 FSM transitions: any state -> FETCH on if_gnt, -> DATA on d_gnt, -> IDLE on no grant.
REQ-030 In FETCH: if_valid=1 and if_rdata=mem_rdata.
REQ-031 In DATA: d_valid=1, and d_rdata=mem_rdata for a load or 0 for a store; the store flag is registered with the grant.
REQ-032 In IDLE, and whenever a channel is not the owner, its valid shall be 0 and its rdata 0.
REQ-033 Response latency shall be exactly one cycle after the grant.
REQ-034 Back-to-back grants shall be legal every cycle; full throughput is one access per cycle.
REQ-035 A requester deasserting its request without a grant shall be ignored and shall not be an error.

Reset
REQ-036 While reset=0, the FSM shall be IDLE, the starve counter 0, and all outputs 0, regardless of requests.
REQ-037 Assertion mid-transaction shall drop any outstanding response: no valid pulse follows reset release.
REQ-038 The first grant shall be possible in the first cycle after reset deasserts.

Verification
REQ-039 Fetch alone: if_req=1, if_addr=0x0010, mem returns 0x13B0 -> if_gnt in cycle N; if_valid=1 and if_rdata=0x13B0 in N+1.
REQ-040 Load vs fetch collision: both request in cycle N -> d_gnt=1, if_gnt=0; d_valid with mem data in N+1; fetch granted in N+1 if d_req is deasserted.
REQ-041 Starvation: d_req held 1 and if_req held 1 with STARVE_LIMIT=3 -> data granted cycles 0-2; fetch granted cycle 3; counter 0; data granted cycle 4.
REQ-042 Store: d_we=1, d_addr=0x0020, d_wdata=0x000B -> mem_we=1 with that address and data in cycle N; d_valid=1 and d_rdata=0 in N+1.
REQ-043 Reset mid-operation: grant in cycle N, then reset=0 asynchronously before edge N+1 -> if_valid=0 and d_valid=0 throughout; outputs 0; grant legal in the first cycle after release.
REQ-044 Idle: no requests for 10 cycles -> mem_en=0 and FSM IDLE every cycle.
